// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the AXI slave to SRAM bridge.
package axi_slave_pkg;

    localparam int C_AXI_ADDR_WTH = 29;
    localparam int C_AXI_DATA_WTH = 64;
    localparam int C_AXI_ID_WTH   = 4;
    localparam int C_MEM_ADDR_WTH = C_AXI_ADDR_WTH - 3;

    typedef enum logic [1:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_DATA
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [2:0] SIZE_8B = 3'd3;

    // Only full-width FIXED/INCR bursts are served; anything else is answered with SLVERR.
    function automatic logic req_err(input logic [2:0] size,
                                     input logic [1:0] burst);
        return (size != SIZE_8B) || (burst >= BURST_WRAP);
    endfunction

endpackage

// File: rtl/axi_slave_if.sv
// AXI channel bundle between our AXI master and the memory bridge.
interface axi_slave_if;
    import axi_slave_pkg::*;

    logic                      awready;
    logic [C_AXI_ID_WTH-1:0]   awid;
    logic [C_AXI_ADDR_WTH-1:0] awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic [3:0]                awcache;
    logic                      awvalid;

    logic                      wready;
    logic [C_AXI_DATA_WTH-1:0] wdata;
    logic [7:0]                wstrb;
    logic                      wlast;
    logic                      wvalid;

    logic [C_AXI_ID_WTH-1:0]   bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    logic                      arready;
    logic [C_AXI_ID_WTH-1:0]   arid;
    logic [C_AXI_ADDR_WTH-1:0] araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic [3:0]                arcache;
    logic                      arvalid;

    logic [C_AXI_ID_WTH-1:0]   rid;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic [C_AXI_DATA_WTH-1:0] rdata;
    logic                      rlast;
    logic                      rready;

    modport slave (
        output awready,
        input  awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
        output wready,
        input  wdata, wstrb, wlast, wvalid,
        output bid, bresp, bvalid,
        input  bready,
        output arready,
        input  arid, araddr, arlen, arsize, arburst, arcache, arvalid,
        output rid, rresp, rvalid, rdata, rlast,
        input  rready
    );

    modport master (
        input  awready,
        output awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
        input  wready,
        output wdata, wstrb, wlast, wvalid,
        input  bid, bresp, bvalid,
        output bready,
        input  arready,
        output arid, araddr, arlen, arsize, arburst, arcache, arvalid,
        input  rid, rresp, rvalid, rdata, rlast,
        output rready
    );

endinterface

// File: rtl/axi_slave_rd_fifo.sv
// Two-entry read-return FIFO carrying {last, data} toward the R channel.
module axi_slave_rd_fifo
    import axi_slave_pkg::*;
#(
    parameter int W = C_AXI_DATA_WTH + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         wp_q;
    logic         rp_q;
    logic [1:0]   cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push) wp_q <= ~wp_q;
            if (pop)  rp_q <= ~rp_q;
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= din;
    end

    assign dout  = mem_q[rp_q];
    assign count = cnt_q;
    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/axi_slave_mem_bridge.sv
// AXI slave that breaks bursts into single-beat SRAM accesses,
// serving one burst at a time with round-robin read/write arbitration.
module axi_slave_mem_bridge
    import axi_slave_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    axi_slave_if.slave                axi,
    output logic                      mem_en,
    output logic [7:0]                mem_we,
    output logic [C_MEM_ADDR_WTH-1:0] mem_addr,
    output logic [C_AXI_DATA_WTH-1:0] mem_wdata,
    input  logic [C_AXI_DATA_WTH-1:0] mem_rdata
);

    state_t state_q;
    state_t state_d;

    logic                      ptr_wr_q;
    logic [C_AXI_ID_WTH-1:0]   id_q;
    logic [C_MEM_ADDR_WTH-1:0] cur_q;
    logic [7:0]                len_q;
    logic                      err_q;
    logic                      fixed_q;
    logic [8:0]                cnt_q;
    logic                      infl_q;
    logic                      infl_last_q;

    logic aw_go;
    logic ar_go;
    logic at_last;
    logic issue;
    logic pop;
    logic [2:0] occ;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic [1:0]                fifo_count;
    logic [C_AXI_DATA_WTH:0]   fifo_din;
    logic [C_AXI_DATA_WTH:0]   fifo_dout;

    // Ready is held low during reset even though the FSM already sits in IDLE.
    assign aw_go = !rst && axi.awvalid && (!axi.arvalid || ptr_wr_q);
    assign ar_go = !rst && axi.arvalid && (!axi.awvalid || !ptr_wr_q);

    assign at_last = (cnt_q == {1'b0, len_q});
    assign occ     = {1'b0, fifo_count} + {2'b00, infl_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        axi.awready = 1'b0;
        axi.arready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 8'h00;
        issue       = 1'b0;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                axi.awready = aw_go;
                axi.arready = ar_go;
                if (aw_go)      state_d = WR_DATA;
                else if (ar_go) state_d = RD_DATA;
            end
            WR_DATA: begin
                axi.wready = 1'b1;
                if (axi.wvalid) begin
                    mem_en = 1'b1;
                    mem_we = err_q ? 8'h00 : axi.wstrb;
                    if (at_last) state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                axi.bvalid = 1'b1;
                if (axi.bready) state_d = IDLE;
            end
            RD_DATA: begin
                // Error bursts still walk the issue slots so timing matches, minus the access.
                issue  = (cnt_q <= {1'b0, len_q}) && (occ < 3'd2);
                mem_en = issue && !err_q;
                pop    = !fifo_empty && axi.rready;
                if (pop && fifo_dout[C_AXI_DATA_WTH]) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_wr_q    <= 1'b1;
            id_q        <= '0;
            cur_q       <= '0;
            len_q       <= 8'd0;
            err_q       <= 1'b0;
            fixed_q     <= 1'b0;
            cnt_q       <= 9'd0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            infl_q      <= issue;
            infl_last_q <= issue && at_last;
            unique case (state_q)
                IDLE: begin
                    if (aw_go) begin
                        id_q    <= axi.awid;
                        cur_q   <= axi.awaddr[C_AXI_ADDR_WTH-1:3];
                        len_q   <= axi.awlen;
                        err_q   <= req_err(axi.awsize, axi.awburst);
                        fixed_q <= (axi.awburst == BURST_FIXED);
                        cnt_q   <= 9'd0;
                    end else if (ar_go) begin
                        id_q    <= axi.arid;
                        cur_q   <= axi.araddr[C_AXI_ADDR_WTH-1:3];
                        len_q   <= axi.arlen;
                        err_q   <= req_err(axi.arsize, axi.arburst);
                        fixed_q <= (axi.arburst == BURST_FIXED);
                        cnt_q   <= 9'd0;
                    end
                end
                WR_DATA: begin
                    if (axi.wvalid) begin
                        cnt_q <= cnt_q + 9'd1;
                        if (!fixed_q) cur_q <= cur_q + 1'b1;
                        if (axi.wlast != at_last) err_q <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (axi.bready) ptr_wr_q <= 1'b0;
                end
                RD_DATA: begin
                    if (issue) begin
                        cnt_q <= cnt_q + 9'd1;
                        if (!fixed_q) cur_q <= cur_q + 1'b1;
                    end
                    if (pop && fifo_dout[C_AXI_DATA_WTH]) ptr_wr_q <= 1'b1;
                end
            endcase
        end
    end

    assign fifo_din = {infl_last_q, (err_q ? {C_AXI_DATA_WTH{1'b0}} : mem_rdata)};

    axi_slave_rd_fifo #(
        .W(C_AXI_DATA_WTH + 1)
    ) u_rd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (infl_q),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign mem_addr  = cur_q;
    assign mem_wdata = axi.wdata;

    assign axi.bid    = id_q;
    assign axi.bresp  = (state_q == WR_RESP && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign axi.rid    = id_q;
    assign axi.rvalid = !fifo_empty;
    assign axi.rresp  = (!fifo_empty && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign axi.rdata  = fifo_empty ? '0 : fifo_dout[C_AXI_DATA_WTH-1:0];
    assign axi.rlast  = !fifo_empty && fifo_dout[C_AXI_DATA_WTH];

    logic unused_ok;
    assign unused_ok = ^{axi.awcache, axi.arcache, axi.awaddr[2:0],
                         axi.araddr[2:0], fifo_full};

endmodule
